mem_bus_arbiter: RTL

- Two-requester controller that shares the single 16-bit line memory bus between, e.g., an instruction cache and a data cache.
- Accepts whole-line (128-bit) read/write requests and serialises each into an 8-beat command burst (C2_READ/C2_WRITE) on the memory bus.
- Reassembles read beats into a line buffer.
- Sits between the caches and the memory model; top level ties mem_data_o/oe/i onto the inout data bus.

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester line-memory controller: arbitrates whole-line read/write
// requests and serialises each into an 8-beat burst on the 16-bit memory bus.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int BUS_SIZE  = 16,
    parameter int LINE_BITS = 128,
    parameter int BEATS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rq0_req,
    input  logic                 rq0_we,
    input  logic [ADDR_W-1:0]    rq0_addr,
    input  logic [LINE_BITS-1:0] rq0_wdata,
    output logic                 rq0_ack,
    input  logic                 rq1_req,
    input  logic                 rq1_we,
    input  logic [ADDR_W-1:0]    rq1_addr,
    input  logic [LINE_BITS-1:0] rq1_wdata,
    output logic                 rq1_ack,
    output logic [LINE_BITS-1:0] rd_line,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [1:0]           mem_cmd,
    output logic [BUS_SIZE-1:0]  mem_data_o,
    output logic                 mem_data_oe,
    input  logic [BUS_SIZE-1:0]  mem_data_i,
    output logic                 busy
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, ACK} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 gnt_q, gnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rd_line_q, rd_line_d;
    logic [1:0]           mem_cmd_q, mem_cmd_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [BUS_SIZE-1:0]  mem_data_o_q, mem_data_o_d;
    logic                 mem_data_oe_q, mem_data_oe_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 busy_q, busy_d;

    logic                 sel_1;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LINE_BITS-1:0] sel_wdata;
    logic [CNT_W-1:0]     cap_idx;
    logic [CNT_W-1:0]     nxt_idx;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_line_d     = rd_line_q;
        mem_cmd_d     = CMD_NOP;
        mem_addr_d    = '0;
        mem_data_o_d  = '0;
        mem_data_oe_d = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;

        // Requester 1 wins when alone, or on a tie when requester 0 went last.
        sel_1     = rq1_req && (!rq0_req || !last_grant_q);
        sel_we    = sel_1 ? rq1_we    : rq0_we;
        sel_addr  = sel_1 ? rq1_addr  : rq0_addr;
        sel_wdata = sel_1 ? rq1_wdata : rq0_wdata;
        // Read data lags the command by one cycle; in RD_TAIL cnt_q is 0 so this wraps to the last beat.
        cap_idx   = cnt_q - 1'b1;
        nxt_idx   = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (rq0_req || rq1_req) begin
                    gnt_d        = sel_1;
                    last_grant_d = sel_1;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    cnt_d        = '0;
                    mem_addr_d   = sel_addr;
                    if (sel_we) begin
                        state_d       = WR;
                        mem_cmd_d     = CMD_WRITE;
                        mem_data_oe_d = 1'b1;
                        mem_data_o_d  = sel_wdata[BUS_SIZE-1:0];
                    end else begin
                        state_d   = RD;
                        mem_cmd_d = CMD_READ;
                    end
                end
            end
            RD: begin
                if (cnt_q != '0)
                    rd_line_d[cap_idx*BUS_SIZE +: BUS_SIZE] = mem_data_i;
                if (cnt_q == LAST_BEAT) begin
                    state_d = RD_TAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = nxt_idx;
                    mem_cmd_d  = CMD_READ;
                    mem_addr_d = addr_q;
                end
            end
            RD_TAIL: begin
                rd_line_d[cap_idx*BUS_SIZE +: BUS_SIZE] = mem_data_i;
                state_d = ACK;
                ack0_d  = !gnt_q;
                ack1_d  = gnt_q;
            end
            WR: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    ack0_d  = !gnt_q;
                    ack1_d  = gnt_q;
                end else begin
                    cnt_d         = nxt_idx;
                    mem_cmd_d     = CMD_WRITE;
                    mem_addr_d    = addr_q;
                    mem_data_oe_d = 1'b1;
                    mem_data_o_d  = wdata_q[nxt_idx*BUS_SIZE +: BUS_SIZE];
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_grant_q  <= 1'b1;
            gnt_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_line_q     <= '0;
            mem_cmd_q     <= CMD_NOP;
            mem_addr_q    <= '0;
            mem_data_o_q  <= '0;
            mem_data_oe_q <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_line_q     <= rd_line_d;
            mem_cmd_q     <= mem_cmd_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_o_q  <= mem_data_o_d;
            mem_data_oe_q <= mem_data_oe_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            busy_q        <= busy_d;
        end
    end

    assign rq0_ack     = ack0_q;
    assign rq1_ack     = ack1_q;
    assign rd_line     = rd_line_q;
    assign mem_cmd     = mem_cmd_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_o  = mem_data_o_q;
    assign mem_data_oe = mem_data_oe_q;
    assign busy        = busy_q;

endmodule
